// File: rtl/fanout_load_monitor.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : fanout_load_monitor                                           |
// | Purpose  : Load-end checker for a fanned-out driver net. Each observed   |
// |            load copy is compared against a delayed image of the driver   |
// |            (per-load programmable latency). Divergence is flagged per    |
// |            load, counted (saturating) and latched into a sticky error.   |
// | Ports    : clk, rst_n        - clock, async active-low reset             |
// |            en, clear         - monitor enable, sync clear to IDLE        |
// |            drv               - driver-side value of the net              |
// |            load_in[N]        - observed value at each load pin           |
// |            load_lat[N*LAT_W] - expected latency of load i at i*LAT_W     |
// |            mismatch_vec[N]   - per-load mismatch of last checked cycle   |
// |            mismatch_cnt      - saturating count of mismatching loads     |
// |            err               - sticky, count reached THRESH              |
// |            state_o           - IDLE=0 WARM=1 CHECK=2 ERR=3               |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module fanout_load_monitor #(
  parameter  int NUM_LOADS = 4,
  parameter  int MAX_LAT   = 4,
  parameter  int CNT_W     = 8,
  parameter  int THRESH    = 1,
  localparam int LAT_W     = (MAX_LAT > 0) ? $clog2(MAX_LAT + 1) : 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       en,
  input  logic                       clear,
  input  logic                       drv,
  input  logic [NUM_LOADS-1:0]       load_in,
  input  logic [NUM_LOADS*LAT_W-1:0] load_lat,
  output logic [NUM_LOADS-1:0]       mismatch_vec,
  output logic [CNT_W-1:0]           mismatch_cnt,
  output logic                       err,
  output logic [1:0]                 state_o
);

  localparam int HIST_W = (MAX_LAT > 0) ? MAX_LAT : 1;
  localparam int PC_W   = $clog2(NUM_LOADS + 1);
  // One spare bit above the wider operand so the add can never wrap
  // before the saturation compare sees it.
  localparam int SUM_W  = ((CNT_W > PC_W) ? CNT_W : PC_W) + 1;

  localparam logic [LAT_W-1:0] LAT_MAX  = LAT_W'(MAX_LAT);
  localparam logic [SUM_W-1:0] CNT_SAT  = {{(SUM_W-CNT_W){1'b0}}, {CNT_W{1'b1}}};
  localparam logic [SUM_W-1:0] THRESH_L = SUM_W'(THRESH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WARM  = 2'd1;
  localparam logic [1:0] S_CHECK = 2'd2;
  localparam logic [1:0] S_ERR   = 2'd3;

  logic [1:0]           state;
  logic [LAT_W-1:0]     warm_cnt;
  logic [HIST_W-1:0]    hist;      // hist[k] = drv (k+1) cycles ago
  logic [NUM_LOADS-1:0] expected;
  logic [NUM_LOADS-1:0] mm;
  logic [PC_W-1:0]      pop;
  logic [SUM_W-1:0]     sum;
  logic [SUM_W-1:0]     cnt_next;
  logic                 hit;

  // Driver history shifts every cycle regardless of state or clear, so a
  // re-enabled monitor only needs the warm-up to refill stale entries.
  generate
    if (HIST_W > 1) begin : g_hist_multi
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) hist <= '0;
        else        hist <= {hist[HIST_W-2:0], drv};
      end
    end else begin : g_hist_single
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) hist <= '0;
        else        hist <= drv;
      end
    end
  endgenerate

  // Per-load expected value: latency 0 is the live driver, larger values
  // tap the history; anything beyond MAX_LAT clamps to the deepest tap.
  generate
    for (genvar i = 0; i < NUM_LOADS; i++) begin : g_load
      logic [LAT_W-1:0] lat_raw;
      logic [LAT_W-1:0] lat_eff;
      logic             exp_bit;

      assign lat_raw = load_lat[i*LAT_W +: LAT_W];
      assign lat_eff = (lat_raw > LAT_MAX) ? LAT_MAX : lat_raw;

      always_comb begin
        exp_bit = drv;
        for (int k = 0; k < HIST_W; k++) begin
          if (lat_eff == LAT_W'(k + 1)) exp_bit = hist[k];
        end
      end

      assign expected[i] = exp_bit;
    end
  endgenerate

  assign mm = load_in ^ expected;

  always_comb begin
    pop = '0;
    for (int i = 0; i < NUM_LOADS; i++) pop = pop + PC_W'(mm[i]);
  end

  assign sum      = {{(SUM_W-CNT_W){1'b0}}, mismatch_cnt} + SUM_W'(pop);
  assign cnt_next = (sum > CNT_SAT) ? CNT_SAT : sum;
  assign hit      = (cnt_next >= THRESH_L);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      warm_cnt     <= '0;
      mismatch_vec <= '0;
      mismatch_cnt <= '0;
      err          <= 1'b0;
    end else if (clear) begin
      state        <= S_IDLE;
      warm_cnt     <= '0;
      mismatch_vec <= '0;
      mismatch_cnt <= '0;
      err          <= 1'b0;
    end else begin
      mismatch_vec <= '0;
      case (state)
        S_IDLE: begin
          if (en) begin
            if (MAX_LAT == 0) begin
              state <= S_CHECK;
            end else begin
              state    <= S_WARM;
              warm_cnt <= LAT_MAX;
            end
          end
        end
        S_WARM: begin
          warm_cnt <= warm_cnt - LAT_W'(1);
          if (!en)                           state <= S_IDLE;
          else if (warm_cnt <= LAT_W'(1))    state <= S_CHECK;
        end
        default: begin  // S_CHECK and S_ERR both compare
          mismatch_vec <= mm;
          mismatch_cnt <= cnt_next[CNT_W-1:0];
          if (hit) err <= 1'b1;
          // The compare of the cycle en falls is still counted above;
          // leaving to IDLE takes priority over entering ERR.
          if (state == S_CHECK) begin
            if (!en)      state <= S_IDLE;
            else if (hit) state <= S_ERR;
          end
        end
      endcase
    end
  end

  assign state_o = state;

endmodule
`default_nettype wire

// File: tb/tb_fanout_load_monitor.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_fanout_load_monitor                                        |
// | Purpose  : Self-checking bench for fanout_load_monitor. Two instances    |
// |            (CNT_W=8/THRESH=1 and CNT_W=4/THRESH=15) share one stimulus.  |
// |            A behavioural model tracks the driver history and monitor     |
// |            mode; every negedge the outputs are compared to it, and       |
// |            scenario points are pinned with literal expectations.         |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_fanout_load_monitor;

  localparam int NL = 4;
  localparam int ML = 4;
  localparam int LW = 3;

  logic            clk   = 1'b0;
  logic            rst_n = 1'b0;
  logic            en    = 1'b0;
  logic            clear = 1'b0;
  logic            drv   = 1'b0;
  logic [NL-1:0]   load_in  = '0;
  logic [NL*LW-1:0] load_lat = '0;

  logic [NL-1:0] vec_a, vec_b;
  logic [7:0]    cnt_a;
  logic [3:0]    cnt_b;
  logic          err_a, err_b;
  logic [1:0]    st_a, st_b;

  int checks = 0;
  int errors = 0;

  fanout_load_monitor #(.NUM_LOADS(NL), .MAX_LAT(ML), .CNT_W(8), .THRESH(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .en(en), .clear(clear), .drv(drv),
    .load_in(load_in), .load_lat(load_lat),
    .mismatch_vec(vec_a), .mismatch_cnt(cnt_a), .err(err_a), .state_o(st_a)
  );

  fanout_load_monitor #(.NUM_LOADS(NL), .MAX_LAT(ML), .CNT_W(4), .THRESH(15)) dut_b (
    .clk(clk), .rst_n(rst_n), .en(en), .clear(clear), .drv(drv),
    .load_in(load_in), .load_lat(load_lat),
    .mismatch_vec(vec_b), .mismatch_cnt(cnt_b), .err(err_b), .state_o(st_b)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  bit            mh [ML];          // mh[k] = drv value (k+1) cycles ago
  int            drive_delay [NL]; // physical delay the bench applies per load
  int            m_state [2];      // 0 idle, 1 warm, 2 check, 3 err
  int            m_warm  [2];
  int            m_cnt   [2];
  int            m_err   [2];
  logic [NL-1:0] m_vec   [2];
  int            cw_of   [2] = '{8, 4};
  int            th_of   [2] = '{1, 15};

  function automatic bit delayed(input int d);
    if (d == 0) return drv;
    return mh[d-1];
  endfunction

  function automatic int lat_of(input int i);
    return int'(load_lat[i*LW +: LW]);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_state[k] = 0; m_warm[k] = 0; m_cnt[k] = 0; m_err[k] = 0; m_vec[k] = '0;
    end
    for (int j = 0; j < ML; j++) mh[j] = 1'b0;
  endtask

  initial begin : model
    logic [NL-1:0] mm;
    int pc, d, maxv;
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        model_reset();
      end else begin
        for (int i = 0; i < NL; i++) begin
          d = lat_of(i);
          if (d > ML) d = ML;
          mm[i] = load_in[i] ^ delayed(d);
        end
        pc = $countones(mm);
        for (int k = 0; k < 2; k++) begin
          maxv = (1 << cw_of[k]) - 1;
          if (clear) begin
            m_state[k] = 0; m_vec[k] = '0; m_cnt[k] = 0; m_err[k] = 0;
          end else if (m_state[k] == 0) begin
            m_vec[k] = '0;
            if (en) begin m_state[k] = 1; m_warm[k] = ML; end
          end else if (m_state[k] == 1) begin
            m_vec[k] = '0;
            if (!en) m_state[k] = 0;
            else begin
              m_warm[k] = m_warm[k] - 1;
              if (m_warm[k] == 0) m_state[k] = 2;
            end
          end else begin
            m_vec[k] = mm;
            m_cnt[k] = (m_cnt[k] + pc > maxv) ? maxv : m_cnt[k] + pc;
            if (m_cnt[k] >= th_of[k]) m_err[k] = 1;
            if (m_state[k] == 2) begin
              if (!en)                       m_state[k] = 0;
              else if (m_cnt[k] >= th_of[k]) m_state[k] = 3;
            end
          end
        end
        for (int j = ML - 1; j > 0; j--) mh[j] = mh[j-1];
        mh[0] = drv;
      end
    end
  end

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  initial begin : compare
    forever begin
      @(negedge clk);
      if (rst_n) begin
        chk("vec_a",   32'(vec_a), 32'(m_vec[0]));
        chk("cnt_a",   32'(cnt_a), m_cnt[0]);
        chk("err_a",   32'(err_a), m_err[0]);
        chk("state_a", 32'(st_a),  m_state[0]);
        chk("vec_b",   32'(vec_b), 32'(m_vec[1]));
        chk("cnt_b",   32'(cnt_b), m_cnt[1]);
        chk("err_b",   32'(err_b), m_err[1]);
        chk("state_b", 32'(st_b),  m_state[1]);
      end
    end
  end

  // ---------------- stimulus ----------------
  // Called at a negedge: picks a random driver bit, drives every load with
  // its physical delay of the driver (optionally inverted), then waits one
  // full cycle so the caller lands on the next negedge.
  task automatic cyc(input logic [NL-1:0] fault);
    drv = 1'($urandom_range(0, 1));
    for (int i = 0; i < NL; i++) load_in[i] = delayed(drive_delay[i]) ^ fault[i];
    @(negedge clk);
  endtask

  task automatic set_lat(input int i, input int v);
    load_lat[i*LW +: LW] = LW'(v);
  endtask

  initial begin : main
    int exp_cnt [5] = '{4, 8, 12, 15, 15};
    int exp_err [5] = '{0, 0, 0, 1, 1};
    int exp_st  [5] = '{2, 2, 2, 3, 3};
    int v;

    drive_delay = '{0, 1, 2, 4};
    set_lat(0, 0); set_lat(1, 1); set_lat(2, 2); set_lat(3, 4);

    // Reset state
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    chk("rst_state_a", 32'(st_a), 0);
    chk("rst_cnt_a",   32'(cnt_a), 0);
    chk("rst_err_a",   32'(err_a), 0);
    chk("rst_vec_a",   32'(vec_a), 0);
    chk("rst_state_b", 32'(st_b), 0);

    // Clean run: four WARM cycles, then CHECK with no mismatches
    en = 1'b1;
    cyc('0);
    chk("warm_first", 32'(st_a), 1);
    repeat (3) cyc('0);
    chk("warm_fourth", 32'(st_a), 1);
    cyc('0);
    chk("check_entry", 32'(st_a), 2);
    repeat (195) cyc('0);
    chk("clean_cnt", 32'(cnt_a), 0);
    chk("clean_err", 32'(err_a), 0);

    // Single fault on load 2
    cyc(4'b0100);
    chk("fault_vec_a",   32'(vec_a), 4);
    chk("fault_cnt_a",   32'(cnt_a), 1);
    chk("fault_err_a",   32'(err_a), 1);
    chk("fault_state_a", 32'(st_a),  3);
    chk("fault_cnt_b",   32'(cnt_b), 1);
    chk("fault_state_b", 32'(st_b),  2);
    cyc('0);
    chk("after_fault_vec_a", 32'(vec_a), 0);
    chk("err_sticky_a",      32'(err_a), 1);

    // Saturation on the 4-bit counter
    clear = 1'b1; cyc('0); clear = 1'b0;
    chk("clr_state_a", 32'(st_a), 0);
    chk("clr_cnt_b",   32'(cnt_b), 0);
    repeat (5) cyc('0);
    chk("sat_in_check", 32'(st_b), 2);
    for (int s = 0; s < 5; s++) begin
      cyc(4'b1111);
      chk("sat_cnt_b",   32'(cnt_b), exp_cnt[s]);
      chk("sat_err_b",   32'(err_b), exp_err[s]);
      chk("sat_state_b", 32'(st_b),  exp_st[s]);
    end

    // Asynchronous reset mid-CHECK with count 5
    clear = 1'b1; cyc('0); clear = 1'b0;
    repeat (5) cyc('0);
    cyc(4'b1111);
    cyc(4'b0001);
    chk("pre_rst_cnt_b",   32'(cnt_b), 5);
    chk("pre_rst_state_b", 32'(st_b),  2);
    #3 rst_n = 1'b0;
    #1;
    chk("async_state_b", 32'(st_b),  0);
    chk("async_cnt_b",   32'(cnt_b), 0);
    chk("async_err_b",   32'(err_b), 0);
    chk("async_vec_b",   32'(vec_b), 0);
    chk("async_state_a", 32'(st_a),  0);
    chk("async_err_a",   32'(err_a), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // en drop in WARM: back to IDLE, faults during warm-up never counted
    cyc(4'b1111);
    cyc(4'b1111);
    chk("drop_in_warm", 32'(st_a), 1);
    en = 1'b0;
    cyc(4'b1111);
    chk("drop_idle_a", 32'(st_a),  0);
    chk("drop_cnt_a",  32'(cnt_a), 0);
    chk("drop_cnt_b",  32'(cnt_b), 0);

    // en fall coinciding with a mismatch in CHECK: still counted, then IDLE
    en = 1'b1;
    repeat (5) cyc('0);
    chk("refill_check_b", 32'(st_b), 2);
    en = 1'b0;
    cyc(4'b0010);
    chk("fall_state_b", 32'(st_b),  0);
    chk("fall_cnt_b",   32'(cnt_b), 1);
    chk("fall_vec_b",   32'(vec_b), 2);
    chk("fall_state_a", 32'(st_a),  0);
    chk("fall_cnt_a",   32'(cnt_a), 1);

    // Re-enable: warm-up again, then the held count drives instance a to ERR
    en = 1'b1;
    repeat (6) cyc('0);
    chk("reen_state_a", 32'(st_a), 3);
    chk("reen_state_b", 32'(st_b), 2);
    clear = 1'b1; cyc('0); clear = 1'b0;
    chk("err_clr_state_a", 32'(st_a),  0);
    chk("err_clr_cnt_a",   32'(cnt_a), 0);
    chk("err_clr_err_a",   32'(err_a), 0);

    // Latency clamp: programmed 7, physically delayed 4
    set_lat(3, 7);
    drive_delay[3] = 4;
    repeat (5) cyc('0);
    repeat (30) cyc('0);
    chk("clamp_cnt_a",   32'(cnt_a), 0);
    chk("clamp_state_a", 32'(st_a),  2);

    // Randomized phase: new latencies programmed while idle, then random
    // en / clear / fault traffic checked cycle by cycle against the model.
    en = 1'b0;
    cyc('0);
    for (int i = 0; i < NL; i++) begin
      v = int'($urandom_range(0, 7));
      set_lat(i, v);
      drive_delay[i] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 4))
                                                   : ((v > ML) ? ML : v);
    end
    for (int n = 0; n < 400; n++) begin
      en    = ($urandom_range(0, 19) != 0);
      clear = ($urandom_range(0, 49) == 0);
      cyc(($urandom_range(0, 5) == 0) ? NL'($urandom_range(0, 15)) : '0);
    end
    clear = 1'b0;
    en    = 1'b0;
    cyc('0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
